if_fetch: RTL and testbench
===========================

# if_fetch

Instruction-fetch stage of the OpenMIPS pipeline. It sits upstream of the IF/ID register and produces the `(pc, inst)` pairs that IF/ID latches. It runs the PC, issues per-cycle requests to instruction ROM, and holds each result in an output slot until IF/ID accepts it. It also applies branch redirects from ID, keeping MIPS delay-slot semantics.

## Interface
- `RESET_PC`, default `32'h0000_0000`: first fetch address after reset.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low (`rst == 0` resets).
- `stall_i`  in  1  IF/ID not accepting this cycle.
- `branch_flag_i`  in  1  one-cycle redirect pulse from ID.
- `branch_target_i`  in  32  redirect address, valid with `branch_flag_i`.
- `rom_ce_o`  out  1  ROM enable; 0 in reset and `S_IDLE`.
- `rom_req_o`  out  1  fetch request this cycle.
- `rom_addr_o`  out  32  fetch address, equals `pc_q`.
- `rom_ack_i`  in  1  ROM data valid this cycle; meaningful only when `rom_req_o` = 1.
- `rom_data_i`  in  32  instruction word.
- `if_valid_o`  out  1  output slot full.
- `if_pc_o`  out  32  address of the held instruction.
- `if_inst_o`  out  32  held instruction.

## Operation
- **ROM protocol:** stateless per cycle. A transfer happens when `rom_req_o && rom_ack_i`, with data sampled at that edge. `rom_req_o` may drop in any cycle; the ROM keeps no outstanding request.
- **Output handshake:** the slot is consumed when `if_valid_o && !stall_i`.
- **`slot_free`** = `!if_valid_o || !stall_i`.
- **FSM:**
  - `S_IDLE`: entered on reset. Goes to `S_FETCH` on the first edge after `rst` rises.
  - `S_FETCH`: `rom_req_o = slot_free`, combinational. On a transfer:
    - `if_pc_o <= pc_q`, `if_inst_o <= rom_data_i`, `if_valid_o <= 1`.
    - `pc_q <= redir_v ? redir_pc : pc_q + 4`, and `redir_v <= 0`.
  - Consume without a transfer: `if_valid_o <= 0`.
- **Redirect:**
  - `branch_flag_i` loads `redir_v <= 1` and `redir_pc <= target`. `pc_q` never changes while it could be on the ROM bus.
  - If there is no transfer in the pulse cycle and `if_valid_o` = 1, the held instruction is the delay slot. `pc_q` is replaced at that edge and `redir_v` stays 0.
  - Pulse in the same cycle as a transfer: the transferred word is the delay slot, and `pc_q <= target` directly.
  - Pulse while `redir_v` = 1: the newer target overwrites the older one.
- **Arithmetic:** `pc_q + 4` is modulo 2^32, so `32'hFFFF_FFFC` wraps to `0`.
- **Reset mid-operation:**
  - Outputs go to reset values immediately.
  - A ROM ack in the reset cycle is ignored.
  - `redir_v` is cleared.

## Timing
- **Reset values:** `rom_ce_o`=0, `rom_req_o`=0, `rom_addr_o`=`RESET_PC`, `if_valid_o`=0, `if_pc_o`=0, `if_inst_o`=0. Internally, `redir_v`=0.
- **Latency:**
  - Edge E0 after `rst` rises: `S_IDLE` → `S_FETCH`.
  - `rom_req_o` is high in the cycle after E0.
  - With a zero-wait ack, `if_valid_o` rises one edge later.
- **Throughput:** one instruction per cycle with a zero-wait ROM and `stall_i` low.
- **Stall:** holds `if_*_o` stable and forces `rom_req_o` low in the same cycle, combinationally.
- **Redirect:** a target fetch is requested no later than the cycle after the delay-slot transfer.

## Configuration
- **`IF_ALIGN_CHK_EN` defined:**
  - Adds output `if_excp_o` (1 bit, reset 0).
  - A redirect whose `target[1:0] != 0` is taken without a ROM request: `if_pc_o` = target, `if_inst_o` = `ZeroWord`, `if_valid_o` = 1, `if_excp_o` = 1.
  - The FSM then enters `S_HALT`, where `rom_req_o` = 0, until the next `branch_flag_i`.
  - `if_excp_o` clears when that slot is consumed.
- **Undefined:** no port, no `S_HALT`; the target is used with `[1:0]` forced to `2'b00`.

## Structure
- **`defines.v`:**
  - Existing: `InstAddrBus`, `InstBus`, `ZeroWord`.
  - New: `RstEnable` as `1'b0` for this block, `IfStateBus` (2 bits), `S_IDLE`/`S_FETCH`/`S_HALT` encodings, `PcStep` (`32'd4`).
- **Sub-module `if_pc_reg`:** holds `pc_q`, `redir_v` and `redir_pc`, and computes the next PC. The FSM and output slot stay in `if_fetch`.

## Test plan
- **Reset then free-run:** release reset with ack tied 1 and `rom_data_i` = `addr ^ 32'hA5A5_0000`. `if_pc_o` must show 0, 4, 8 on consecutive cycles starting 2 edges after release, with matching `if_inst_o`.
- **Stall:** hold `stall_i` high 3 cycles while the slot holds pc 8. Required: `rom_req_o` = 0 and `if_pc_o` = 8 throughout, and pc 12 follows the cycle after release.
- **Wait states:** ack every third cycle. Required: no skipped or duplicated PCs, and `rom_addr_o` stable while unacked.
- **Branch:**
  - Pulse target `32'h0000_0100` in the transfer cycle of pc 0x10. Output sequence: 0x10, then 0x100.
  - Repeat with the pulse during an unacked request for 0x14. Output sequence: 0x14, then 0x100.
- **Wrap and async reset:**
  - Redirect to `32'hFFFF_FFFC`. The next PC must be 0.
  - Assert `rst` mid-cycle. `if_valid_o` must drop before the next edge.
- **With `IF_ALIGN_CHK_EN`:** redirect to `32'h0000_0102`. Required: `if_excp_o` = 1, `if_inst_o` = 0, no ROM request until a new pulse.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: widths, FSM encodings and constants for the
// OpenMIPS fetch stage (IF_ALIGN_CHK_EN adds S_HALT use).
package if_fetch_pkg;
  localparam int InstAddrW = 32;
  localparam int InstW = 32;
  localparam int IfStateW = 2;

  typedef logic [InstAddrW-1:0] inst_addr_t;
  typedef logic [InstW-1:0] inst_t;

  localparam inst_t ZeroWord = '0;
  localparam logic RstEnable = 1'b0;
  localparam inst_addr_t PcStep = 32'd4;

  localparam logic [IfStateW-1:0] S_IDLE = 2'd0;
  localparam logic [IfStateW-1:0] S_FETCH = 2'd1;
  localparam logic [IfStateW-1:0] S_HALT = 2'd2;

  function automatic inst_addr_t word_align(
    input inst_addr_t a
  );
    return a & ~inst_addr_t'(3);
  endfunction
endpackage

// File: rtl/if_pc_reg.sv
// if_pc_reg: fetch PC and pending branch redirect.
// IF_ALIGN_CHK_EN keeps target[1:0] so the trap path sees it.
module if_pc_reg
  import if_fetch_pkg::*;
#(
  parameter inst_addr_t RESET_PC = 32'h0000_0000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_xfer,
  input  logic       i_branch,
  input  logic       i_direct,
  input  inst_addr_t i_target,
  output inst_addr_t o_pc
);

  inst_addr_t r_pc;
  inst_addr_t r_redir_pc;
  logic       r_redir_v;
  inst_addr_t w_tgt;

`ifdef IF_ALIGN_CHK_EN
  assign w_tgt = i_target;
`else
  assign w_tgt = word_align(i_target);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      r_pc       <= RESET_PC;
      r_redir_v  <= 1'b0;
      r_redir_pc <= '0;
    end else if (i_branch && i_direct) begin
      // delay slot is held or moving into the slot now
      r_pc      <= w_tgt;
      r_redir_v <= 1'b0;
    end else if (i_branch) begin
      r_redir_v  <= 1'b1;
      r_redir_pc <= w_tgt;
    end else if (i_xfer) begin
      r_pc      <= r_redir_v ? r_redir_pc : r_pc + PcStep;
      r_redir_v <= 1'b0;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/if_fetch.sv
// if_fetch: OpenMIPS IF stage - PC, ROM requests, output slot.
// IF_ALIGN_CHK_EN adds if_excp_o and the S_HALT trap state.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        rom_ce_o,
  output logic        rom_req_o,
  output logic [31:0] rom_addr_o,
  input  logic        rom_ack_i,
  input  logic [31:0] rom_data_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o
`ifdef IF_ALIGN_CHK_EN
  ,
  output logic        if_excp_o
`endif
);

  logic [IfStateW-1:0] r_state;
  logic                r_valid;
  inst_addr_t          r_pc;
  inst_t               r_inst;

  inst_addr_t w_pc;
  logic       w_slot_free;
  logic       w_fetch;
  logic       w_misal;
  logic       w_halt;
  logic       w_xfer;
  logic       w_cons;
  logic       w_direct;

  assign w_slot_free = !r_valid || !stall_i;
  assign w_fetch     = r_state == S_FETCH;

`ifdef IF_ALIGN_CHK_EN
  logic r_excp;
  logic w_excp_ld;
  assign w_misal   = w_pc[1:0] != 2'b00;
  assign w_halt    = r_state == S_HALT;
  assign w_excp_ld = w_fetch && w_slot_free && w_misal;
`else
  assign w_misal = 1'b0;
  assign w_halt  = 1'b0;
`endif

  assign rom_req_o  = w_fetch && w_slot_free && !w_misal;
  assign rom_ce_o   = r_state != S_IDLE;
  assign rom_addr_o = w_pc;

  assign w_xfer   = rom_req_o && rom_ack_i;
  assign w_cons   = r_valid && !stall_i;
  assign w_direct = w_xfer || r_valid || w_halt;

  if_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .rst      (rst),
    .i_xfer   (w_xfer),
    .i_branch (branch_flag_i),
    .i_direct (w_direct),
    .i_target (branch_target_i),
    .o_pc     (w_pc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_FETCH;
`ifdef IF_ALIGN_CHK_EN
        S_FETCH:
          if (w_excp_ld) r_state <= S_HALT;
        S_HALT:
          if (branch_flag_i) r_state <= S_FETCH;
`else
        S_FETCH: r_state <= S_FETCH;
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_inst  <= ZeroWord;
    end else if (w_xfer) begin
      r_valid <= 1'b1;
      r_pc    <= w_pc;
      r_inst  <= rom_data_i;
`ifdef IF_ALIGN_CHK_EN
    end else if (w_excp_ld) begin
      r_valid <= 1'b1;
      r_pc    <= w_pc;
      r_inst  <= ZeroWord;
`endif
    end else if (w_cons) begin
      r_valid <= 1'b0;
    end
  end

`ifdef IF_ALIGN_CHK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      r_excp <= 1'b0;
    end else if (w_xfer) begin
      r_excp <= 1'b0;
    end else if (w_excp_ld) begin
      r_excp <= 1'b1;
    end else if (w_cons) begin
      r_excp <= 1'b0;
    end
  end

  assign if_excp_o = r_excp;
`endif

  assign if_valid_o = r_valid;
  assign if_pc_o    = r_pc;
  assign if_inst_o  = r_inst;

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: randomized and directed bench for if_fetch
// against an instruction-stream reference model.
module tb_if_fetch;
  localparam logic [31:0] K = 32'hA5A5_0000;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_i = 1'b0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        rom_ack_i = 1'b0;
  logic [31:0] rom_data_i;
  logic        rom_ce_o, rom_req_o, if_valid_o;
  logic [31:0] rom_addr_o, if_pc_o, if_inst_o;
`ifdef IF_ALIGN_CHK_EN
  logic        if_excp_o;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // model: next PC to be delivered, plus pending target
  logic        m_fetch, m_v, m_pend_v;
  logic [31:0] m_pc, m_inst, m_next, m_pend_t;
  logic        e_req, e_xfer;
  logic [31:0] dq[$];

  always #5 clk = ~clk;
  assign rom_data_i = rom_addr_o ^ K;

  if_fetch #(.RESET_PC(RST_PC)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .rom_ce_o        (rom_ce_o),
    .rom_req_o       (rom_req_o),
    .rom_addr_o      (rom_addr_o),
    .rom_ack_i       (rom_ack_i),
    .rom_data_i      (rom_data_i),
    .if_valid_o      (if_valid_o),
    .if_pc_o         (if_pc_o),
    .if_inst_o       (if_inst_o)
`ifdef IF_ALIGN_CHK_EN
    ,
    .if_excp_o       (if_excp_o)
`endif
  );

  task automatic model_reset();
    m_fetch = 1'b0; m_v = 1'b0; m_pend_v = 1'b0;
    m_pc = '0; m_inst = '0; m_next = RST_PC; m_pend_t = '0;
  endtask

  task automatic drive(input logic s, input logic a,
                       input logic b, input logic [31:0] t);
    stall_i = s; rom_ack_i = a;
    branch_flag_i = b; branch_target_i = t;
    e_req  = m_fetch && (!m_v || !s);
    e_xfer = e_req && a;
    #4;
  endtask

  task automatic advance();
    logic [31:0] tg;
    logic        live;
    live = rst;
    if (!live) model_reset();
    else begin
      if (branch_flag_i) begin
        tg = branch_target_i;
`ifndef IF_ALIGN_CHK_EN
        tg[1:0] = 2'b00;
`endif
        if (m_v && !e_xfer) begin
          m_next = tg; m_pend_v = 1'b0;
        end else begin
          m_pend_v = 1'b1; m_pend_t = tg;
        end
      end
      if (e_xfer) begin
        m_pc = m_next; m_inst = m_next ^ K; m_v = 1'b1;
        m_next = m_pend_v ? m_pend_t : m_next + 32'd4;
        m_pend_v = 1'b0;
      end else if (m_v && !stall_i) m_v = 1'b0;
      m_fetch = 1'b1;
    end
    @(posedge clk); #1;
    if (live && rst && e_xfer) dq.push_back(if_pc_o);
  endtask

  task automatic restart();
    rst = 1'b0; drive(0, 0, 0, 0); advance();
    rst = 1'b1; drive(0, 0, 0, 0); advance();
  endtask

  task automatic test_reset();
    rst = 1'b0; model_reset();
    drive(0, 1, 0, 0);
    n_cmp++; if (rom_ce_o !== 1'b0) begin n_bad++;
      $display("FAIL reset_ce got %b want 0", rom_ce_o); end
    n_cmp++; if (rom_req_o !== 1'b0) begin n_bad++;
      $display("FAIL reset_req got %b want 0", rom_req_o); end
    n_cmp++; if (rom_addr_o !== RST_PC) begin n_bad++;
      $display("FAIL reset_addr got %h want %h", rom_addr_o, RST_PC); end
    n_cmp++; if (if_valid_o !== 1'b0) begin n_bad++;
      $display("FAIL reset_valid got %b want 0", if_valid_o); end
    n_cmp++; if (if_pc_o !== 32'h0) begin n_bad++;
      $display("FAIL reset_pc got %h want 0", if_pc_o); end
    n_cmp++; if (if_inst_o !== 32'h0) begin n_bad++;
      $display("FAIL reset_inst got %h want 0", if_inst_o); end
`ifdef IF_ALIGN_CHK_EN
    n_cmp++; if (if_excp_o !== 1'b0) begin n_bad++;
      $display("FAIL reset_excp got %b want 0", if_excp_o); end
`endif
    advance();
    drive(0, 1, 0, 0);
    n_cmp++; if (rom_req_o !== 1'b0 || if_valid_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_hold req %b valid %b want 0 0",
               rom_req_o, if_valid_o); end
    advance();
  endtask

  task automatic test_free_run();
    rst = 1'b1; dq.delete();
    drive(0, 1, 0, 0);
    n_cmp++; if (rom_req_o !== 1'b0) begin n_bad++;
      $display("FAIL idle_req got %b want 0", rom_req_o); end
    advance();
    drive(0, 1, 0, 0);
    n_cmp++; if (rom_req_o !== 1'b1 || rom_addr_o !== 32'h0) begin
      n_bad++;
      $display("FAIL first_req req %b addr %h want 1 0",
               rom_req_o, rom_addr_o); end
    n_cmp++; if (if_valid_o !== 1'b0) begin n_bad++;
      $display("FAIL first_valid got %b want 0", if_valid_o); end
    advance();
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 0, 0);
      n_cmp++;
      if (if_valid_o !== 1'b1 || if_pc_o !== 32'(i * 4) ||
          if_inst_o !== (32'(i * 4) ^ K)) begin
        n_bad++;
        $display("FAIL free_run v %b pc %h inst %h want pc %h",
                 if_valid_o, if_pc_o, if_inst_o, 32'(i * 4));
      end
      advance();
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0);
      n_cmp++;
      if (rom_req_o !== 1'b0 || if_valid_o !== 1'b1 ||
          if_pc_o !== 32'h8 || if_inst_o !== (32'h8 ^ K)) begin
        n_bad++;
        $display("FAIL stall req %b v %b pc %h inst %h want 0 1 8",
                 rom_req_o, if_valid_o, if_pc_o, if_inst_o);
      end
      advance();
    end
    drive(0, 1, 0, 0);
    n_cmp++; if (rom_req_o !== 1'b1 || rom_addr_o !== 32'hC) begin
      n_bad++;
      $display("FAIL stall_rel req %b addr %h want 1 c",
               rom_req_o, rom_addr_o); end
    advance();
    drive(0, 1, 0, 0);
    n_cmp++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'hC) begin
      n_bad++;
      $display("FAIL stall_next v %b pc %h want 1 c",
               if_valid_o, if_pc_o); end
    advance();
  endtask

  task automatic test_wait_states();
    logic [31:0] prev;
    logic        pend;
    logic        a;
    pend = 1'b0; prev = '0; dq.delete();
    for (int i = 0; i < 30; i++) begin
      a = (i % 3) == 2;
      drive(0, a, 0, 0);
      if (pend) begin
        n_cmp++; if (rom_addr_o !== prev) begin n_bad++;
          $display("FAIL addr_stable got %h want %h", rom_addr_o, prev);
        end
      end
      n_cmp++; if (rom_req_o !== e_req) begin n_bad++;
        $display("FAIL ws_req got %b want %b", rom_req_o, e_req); end
      pend = rom_req_o && !a; prev = rom_addr_o;
      advance();
    end
    n_cmp++; if (dq.size() != 10) begin n_bad++;
      $display("FAIL ws_count got %0d want 10", dq.size()); end
    for (int k = 0; k < dq.size(); k++) begin
      n_cmp++; if (dq[k] !== 32'(20 + 4 * k)) begin n_bad++;
        $display("FAIL ws_seq[%0d] got %h want %h",
                 k, dq[k], 32'(20 + 4 * k)); end
    end
  endtask

  task automatic test_branch();
    logic b;
    int   n;
    restart(); dq.delete();
    for (int i = 0; i < 8; i++) begin
      b = m_next == 32'h10;
      drive(0, 1, b, 32'h100);
      if (b) begin
        n_cmp++; if (rom_addr_o !== 32'h10 || rom_req_o !== 1'b1) begin
          n_bad++;
          $display("FAIL br_xfer addr %h req %b want 10 1",
                   rom_addr_o, rom_req_o); end
      end
      advance();
    end
    n_cmp++;
    if (dq.size() < 7) begin n_bad++;
      $display("FAIL br1_len got %0d want 8", dq.size()); end
    else if (dq[4] !== 32'h10 || dq[5] !== 32'h100 ||
             dq[6] !== 32'h104) begin
      n_bad++;
      $display("FAIL br1_seq got %h %h %h want 10 100 104",
               dq[4], dq[5], dq[6]);
    end
    restart();
    n = 0;
    while (m_next != 32'h14 && n < 16) begin
      drive(0, 1, 0, 0); advance(); n++;
    end
    n_cmp++; if (n >= 16) begin n_bad++;
      $display("FAIL br2_reach got n=%0d want <16", n); end
    dq.delete();
    drive(0, 0, 0, 0); advance();
    drive(0, 0, 1, 32'h100);
    n_cmp++;
    if (rom_req_o !== 1'b1 || rom_addr_o !== 32'h14 ||
        if_valid_o !== 1'b0) begin
      n_bad++;
      $display("FAIL br2_pulse req %b addr %h v %b want 1 14 0",
               rom_req_o, rom_addr_o, if_valid_o);
    end
    advance();
    for (int i = 0; i < 3; i++) begin drive(0, 1, 0, 0); advance(); end
    n_cmp++;
    if (dq.size() != 3 || dq[0] !== 32'h14 || dq[1] !== 32'h100 ||
        dq[2] !== 32'h104) begin
      n_bad++;
      $display("FAIL br2_seq n %0d first %h want 3 items 14 100 104",
               dq.size(), dq.size() > 0 ? dq[0] : 32'hx);
    end
  endtask

  task automatic test_wrap();
    dq.delete();
    drive(0, 1, 1, 32'hFFFF_FFFC); advance();
    for (int i = 0; i < 3; i++) begin drive(0, 1, 0, 0); advance(); end
    n_cmp++;
    if (dq.size() != 4) begin n_bad++;
      $display("FAIL wrap_len got %0d want 4", dq.size()); end
    else if (dq[1] !== 32'hFFFF_FFFC || dq[2] !== 32'h0 ||
             dq[3] !== 32'h4) begin
      n_bad++;
      $display("FAIL wrap_seq got %h %h %h want fffffffc 0 4",
               dq[1], dq[2], dq[3]);
    end
`ifndef IF_ALIGN_CHK_EN
    dq.delete();
    drive(0, 1, 1, 32'h102); advance();
    for (int i = 0; i < 2; i++) begin drive(0, 1, 0, 0); advance(); end
    n_cmp++;
    if (dq.size() != 3 || dq[1] !== 32'h100) begin n_bad++;
      $display("FAIL mask_tgt n %0d got %h want 100",
               dq.size(), dq.size() > 1 ? dq[1] : 32'hx); end
`endif
  endtask

  task automatic test_async_reset();
    stall_i = 1'b0; rom_ack_i = 1'b1; branch_flag_i = 1'b0;
    #2;
    n_cmp++; if (if_valid_o !== 1'b1) begin n_bad++;
      $display("FAIL pre_rst_valid got %b want 1", if_valid_o); end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (if_valid_o !== 1'b0 || rom_req_o !== 1'b0 ||
        rom_ce_o !== 1'b0 || rom_addr_o !== RST_PC ||
        if_pc_o !== 32'h0 || if_inst_o !== 32'h0) begin
      n_bad++;
      $display("FAIL async_rst v %b req %b ce %b addr %h pc %h want 0s",
               if_valid_o, rom_req_o, rom_ce_o, rom_addr_o, if_pc_o);
    end
    @(posedge clk); #1;
    model_reset();
    n_cmp++; if (if_valid_o !== 1'b0) begin n_bad++;
      $display("FAIL rst_ack_ignored got %b want 0", if_valid_o); end
  endtask

  task automatic test_random();
    logic s, a, b;
    logic [31:0] t;
    restart();
    for (int c = 0; c < 400; c++) begin
      s = ($urandom % 10) < 3;
      a = ($urandom % 10) < 6;
      b = ($urandom % 20) == 0;
      t = $urandom & 32'hFFFF_FFFC;
      drive(s, a, b, t);
      n_cmp++; if (rom_req_o !== e_req) begin n_bad++;
        $display("FAIL rnd_req cyc %0d got %b want %b",
                 c, rom_req_o, e_req); end
      if (e_req) begin
        n_cmp++; if (rom_addr_o !== m_next) begin n_bad++;
          $display("FAIL rnd_addr cyc %0d got %h want %h",
                   c, rom_addr_o, m_next); end
      end
      n_cmp++; if (if_valid_o !== m_v) begin n_bad++;
        $display("FAIL rnd_valid cyc %0d got %b want %b",
                 c, if_valid_o, m_v); end
      if (m_v) begin
        n_cmp++;
        if (if_pc_o !== m_pc || if_inst_o !== m_inst) begin n_bad++;
          $display("FAIL rnd_slot cyc %0d pc %h inst %h want %h %h",
                   c, if_pc_o, if_inst_o, m_pc, m_inst); end
      end
      advance();
    end
  endtask

`ifdef IF_ALIGN_CHK_EN
  task automatic test_align();
    restart();
    for (int i = 0; i < 3; i++) begin drive(0, 1, 0, 0); advance(); end
    drive(0, 1, 1, 32'h102); advance();
    drive(0, 1, 0, 0);
    n_cmp++; if (rom_req_o !== 1'b0) begin n_bad++;
      $display("FAIL al_noreq got %b want 0", rom_req_o); end
    advance();
    drive(0, 1, 0, 0);
    n_cmp++;
    if (if_excp_o !== 1'b1 || if_valid_o !== 1'b1 ||
        if_pc_o !== 32'h102 || if_inst_o !== 32'h0) begin
      n_bad++;
      $display("FAIL al_slot excp %b v %b pc %h inst %h want 1 1 102 0",
               if_excp_o, if_valid_o, if_pc_o, if_inst_o);
    end
    advance();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0);
      n_cmp++; if (rom_req_o !== 1'b0 || if_excp_o !== 1'b0) begin
        n_bad++;
        $display("FAIL al_halt req %b excp %b want 0 0",
                 rom_req_o, if_excp_o); end
      advance();
    end
    drive(0, 1, 1, 32'h200); advance();
    drive(0, 1, 0, 0);
    n_cmp++; if (rom_req_o !== 1'b1 || rom_addr_o !== 32'h200) begin
      n_bad++;
      $display("FAIL al_resume req %b addr %h want 1 200",
               rom_req_o, rom_addr_o); end
    advance();
  endtask
`endif

  initial begin
    model_reset();
    @(posedge clk); #1;
    test_reset();
    test_free_run();
    test_stall();
    test_wait_states();
    test_branch();
    test_wrap();
    test_async_reset();
    test_random();
`ifdef IF_ALIGN_CHK_EN
    test_align();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
